// File: rtl/alu_result_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo_if
// Description : Producer/consumer bundle for the ALU result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_fifo_if #(
  parameter int PTR_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_sum;
  logic             in_cout;
  logic             in_a_sign;
  logic             in_b_sign;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic [3:0]       out_flags;
  logic [PTR_W:0]   count;
  logic             drop_err;

  // FIFO side
  modport slave (
    input  in_valid, in_sum, in_cout, in_a_sign, in_b_sign, flush, out_ready,
    output in_ready, out_valid, out_sum, out_flags, count, drop_err
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_sum, in_cout, in_a_sign, in_b_sign, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_flags, count, drop_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : Captures adder results, derives {V,N,C,Z} flags and buffers
//               them in a circular FIFO drained over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_fifo_if.slave    bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [15:0]      sum_mem_q   [DEPTH];
  logic [3:0]       flags_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             drop_err_q, drop_err_d;

  logic             full;
  logic             empty;
  logic             push_en;
  logic             pop_en;
  logic [3:0]       flags_in;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // {V,N,C,Z} from the low result byte
  always_comb begin
    flags_in    = 4'b0000;
    flags_in[3] = (bus.in_a_sign == bus.in_b_sign) && (bus.in_sum[7] != bus.in_a_sign);
    flags_in[2] = bus.in_sum[7];
    flags_in[1] = bus.in_cout;
    flags_in[0] = (bus.in_sum[7:0] == 8'h00);
  end

  // Refusal at full holds even when a pop occurs in the same cycle
  assign push_en = bus.in_valid && !full  && !bus.flush;
  assign pop_en  = bus.out_ready && !empty && !bus.flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_err_d = drop_err_q;

    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_err_d = 1'b0;
    end else begin
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
      if (bus.in_valid && full) begin
        drop_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage carries no reset; occupancy alone qualifies its contents
  always_ff @(posedge clk) begin
    if (push_en) begin
      sum_mem_q[wr_ptr_q]   <= bus.in_sum;
      flags_mem_q[wr_ptr_q] <= flags_in;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_sum   = empty ? 16'h0000 : sum_mem_q[rd_ptr_q];
  assign bus.out_flags = empty ? 4'h0     : flags_mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.drop_err  = drop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_fifo
// Description : Directed scoreboard bench for alu_result_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct packed {
    logic [15:0] sum;
    logic [3:0]  flags;
  } entry_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  entry_t sb[$];
  logic   mdrop = 1'b0;
  int     n_pass = 0;
  int     n_total = 0;
  int     n_fail = 0;

  alu_result_fifo_if #(.PTR_W(PTR_W)) bus ();

  alu_result_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_flags(input logic [15:0] s, input logic c,
                                             input logic as, input logic bs);
    logic v, n, z;
    v = (as == bs) && (s[7] != as);
    n = s[7];
    z = (s[7:0] == 8'h00);
    return {v, n, c, z};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check head against scoreboard, advance model, check state
  task automatic cycle(input logic v, input logic [15:0] s, input logic c,
                       input logic as, input logic bs, input logic ordy, input logic fl);
    entry_t e;
    int     sz;
    logic   pushed, popped;
    bus.in_valid  = v;
    bus.in_sum    = s;
    bus.in_cout   = c;
    bus.in_a_sign = as;
    bus.in_b_sign = bs;
    bus.out_ready = ordy;
    bus.flush     = fl;
    sz = sb.size();
    check("out_valid", 32'(bus.out_valid), 32'(sz != 0));
    check("in_ready",  32'(bus.in_ready),  32'(sz != DEPTH));
    if (sz != 0) begin
      e = sb[0];
      check("out_sum",   32'(bus.out_sum),   32'(e.sum));
      check("out_flags", 32'(bus.out_flags), 32'(e.flags));
    end else begin
      check("out_sum_idle",   32'(bus.out_sum),   32'h0);
      check("out_flags_idle", 32'(bus.out_flags), 32'h0);
    end
    if (fl) begin
      sb.delete();
      mdrop = 1'b0;
    end else begin
      popped = (sz != 0) && ordy;
      pushed = v && (sz != DEPTH);
      if (v && sz == DEPTH) mdrop = 1'b1;
      if (popped) void'(sb.pop_front());
      if (pushed) sb.push_back({s, model_flags(s, c, as, bs)});
    end
    @(posedge clk);
    #1;
    check("count",    32'(bus.count),    32'(sb.size()));
    check("drop_err", 32'(bus.drop_err), 32'(mdrop));
  endtask

  initial begin : stim
    logic [3:0] expf [4];
    expf[0] = 4'b0011;
    expf[1] = 4'b1100;
    expf[2] = 4'b1010;
    expf[3] = 4'b0100;

    bus.in_valid  = 1'b0;
    bus.in_sum    = 16'h0000;
    bus.in_cout   = 1'b0;
    bus.in_a_sign = 1'b0;
    bus.in_b_sign = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'h1);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_sum",   32'(bus.out_sum),   32'h0);
    check("rst_out_flags", 32'(bus.out_flags), 32'h0);
    check("rst_count",     32'(bus.count),     32'h0);
    check("rst_drop_err",  32'(bus.drop_err),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single push, visible the following cycle
    cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("single_flags", 32'(bus.out_flags), 32'h0);
    check("single_sum",   32'(bus.out_sum),   32'h0005);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flag coverage
    cycle(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h007F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h0090, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("flag_const", 32'(bus.out_flags), 32'(expf[i]));
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("full_count",    32'(bus.count),    32'h4);
    check("full_in_ready", 32'(bus.in_ready), 32'h0);
    check("full_drop_err", 32'(bus.drop_err), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Streaming push/pop across pointer wrap; upper byte kept unmasked
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      check("stream_count", 32'(bus.count), 32'h1);
    end
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Full with simultaneous pop: only the pop happens
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'hA0F0 + 16'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fullpop_count",    32'(bus.count),    32'h3);
    check("fullpop_in_ready", 32'(bus.in_ready), 32'h1);

    // Flush beats a concurrent push
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("flush_out_valid", 32'(bus.out_valid), 32'h0);
    check("flush_in_ready",  32'(bus.in_ready),  32'h1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges
    cycle(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'h2);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'h0);
    check("async_count",     32'(bus.count),     32'h0);
    check("async_in_ready",  32'(bus.in_ready),  32'h1);
    check("async_out_sum",   32'(bus.out_sum),   32'h0);
    sb.delete();
    mdrop = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 16'h0F81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_fifo.md
# alu_result_fifo

Downstream capture stage for the 8-bit ALU adder. Accepts each 16-bit SUM / COUT result with the two operand sign bits. Derives a 4-bit status flag word per result and buffers result plus flags in a small FIFO. Results drain to the consumer (register file / display stage) over a valid/ready handshake, decoupling adder timing from consumer back-pressure.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16
- PTR_W, 2, log2(DEPTH); pointer width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  producer has a result this cycle (driven with enable_add)
- in_ready  output  1  FIFO can accept; equals not-full
- in_sum  input  16  adder SUM; only bits [7:0] carry data
- in_cout  input  1  adder carry out
- in_a_sign  input  1  operand a bit 7
- in_b_sign  input  1  operand b bit 7
- flush  input  1  synchronous clear of all entries
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head
- out_sum  output  16  head result
- out_flags  output  4  head flags {V,N,C,Z}
- count  output  PTR_W+1  occupied entries, 0..DEPTH
- drop_err  output  1  sticky: in_valid seen while full

## Operation
- Push when in_valid && in_ready. Stores in_sum and flags computed from the current inputs.
- Flag rules, all from the 8-bit result:
  - Z = (in_sum[7:0] == 0)
  - C = in_cout
  - N = in_sum[7]
  - V = (in_a_sign == in_b_sign) && (in_sum[7] != in_a_sign)
- Flags are computed combinationally at the input and stored, not recomputed at the output.
- in_sum[15:8] is stored as presented, with no masking.
- Pop when out_valid && out_ready. Advances the head.
- Storage is a circular buffer:
  - Write and read pointers are PTR_W bits and wrap DEPTH-1 -> 0.
  - The count register disambiguates full from empty.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready.
- When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- out_sum / out_flags present the head entry when out_valid = 1, and are forced to 0 when out_valid = 0.
- Simultaneous push and pop with 0 < count < DEPTH:
  - Both pointers advance and count is unchanged.
  - At count == 0 only the push takes effect; there is no fall-through.
- Overflow error:
  - drop_err sets on any cycle with in_valid && !in_ready, and the input data is discarded.
  - drop_err clears only on rst or flush.
- flush has priority over push and pop in the same cycle. It zeroes the pointers, count and drop_err. Storage contents are don't-care.

## Timing
- Reset values:
  - Output signals: in_ready = 1, out_valid = 0, out_sum = 0, out_flags = 0, count = 0, drop_err = 0.
  - Internal state: pointers = 0.
- Reset is asynchronous: outputs take reset values immediately on rst assertion, mid-transfer included. Any in-flight push or pop that cycle is lost.
- Push-to-output latency is 1 cycle. Data pushed at edge N appears with out_valid = 1 after edge N, so the consumer sees it in cycle N+1.
- Throughput is one push and one pop per cycle when 0 < count < DEPTH.
- in_ready falls in the cycle after the edge that makes count = DEPTH. It rises the cycle after the first pop from full.
- count updates at the same edge as the pointer change.
- flush takes effect at the next rising edge. After that edge, out_valid = 0 and in_ready = 1.

## Test plan
- Reset and single push:
  - Stimulus: assert rst, release it, then push in_sum = 0x0005, cout = 0, signs 0/0.
  - Required response: during reset all outputs are 0 and in_ready = 1. Next cycle out_valid = 1, out_sum = 0x0005, out_flags = 0b0000, count = 1.
- Flag coverage:
  - Stimulus: push the four results below.
    - sum 0x0000 with cout 1 (0xFF + 0x01)
    - sum 0x0080 with signs 0/0 (0x7F + 0x01)
    - sum 0x007F with signs 1/1 (0x80 + 0xFF)
    - sum 0x0090 with signs 1/0
  - Required response: popped flags are 0b0011, 0b1100, 0b1010, 0b0100 in that order.
- Fill and overflow:
  - Stimulus: hold out_ready = 0 and push 5 results 0x0001..0x0005.
  - Required response: count reaches 4 and in_ready = 0. The fifth push is dropped and drop_err = 1. Draining then yields 0x0001..0x0004 in order and count returns to 0.
- Wrap-around with concurrent push/pop:
  - Stimulus: stream 10 results with in_valid and out_ready both held high.
  - Required response: outputs arrive in order with 1-cycle latency, count stays at 1 after the first cycle, and the pointers wrap without loss.
- Full with pop:
  - Stimulus: with count = 4, assert in_valid and out_ready together.
  - Required response: only the pop occurs, count = 3, and in_ready = 1 in the next cycle.
- Flush and async reset mid-stream:
  - Stimulus (flush): with count = 3 and drop_err = 1, assert flush together with in_valid.
  - Required response: count = 0, drop_err = 0, out_valid = 0, and the concurrent push is ignored.
  - Stimulus (reset): assert rst between clock edges while count = 2.
  - Required response: out_valid goes to 0 before the next edge.
